wr_bus_master: RTL

WR_BUS_MASTER -- requirements
Module: wr_bus_master

---
 rtl/wr_bus_pkg.sv | 23 ++
 rtl/cmd_fifo.sv | 61 ++++++
 rtl/wr_bus_master.sv | 103 ++++++++++
 3 files changed

// File: rtl/wr_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wr_bus_pkg
// Brief    : Shared FSM state and bus command types for wr_bus_master.
// Revision : 1.0
// ============================================================================
package wr_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] wdata;
    } bus_cmd_t;

    localparam int c_cmd_w = $bits(bus_cmd_t);

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cmd_fifo
// Brief    : Synchronous FIFO of bus commands with show-ahead head output.
// Revision : 1.0
// ============================================================================
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int             c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]  c_full = (c_aw + 1)'(DEPTH);
    localparam logic [c_aw:0]  c_one  = (c_aw + 1)'(1);
    localparam logic [c_aw-1:0] c_inc = c_aw'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_full);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + c_inc;
            if (w_do_pop)  r_rptr <= r_rptr + c_inc;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/wr_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : wr_bus_master
// Brief    : Queues write requests and replays them as paced bus writes.
// Revision : 1.0
// ============================================================================
module wr_bus_master
    import wr_bus_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_addr,
    input  logic [7:0]  req_wdata,
    output logic        en,
    output logic        wr,
    output logic [7:0]  addr,
    output logic [7:0]  wdata,
    output logic [15:0] wr_count,
    output logic        busy
);

    localparam logic [3:0] c_gap_load = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t     r_state;
    logic [3:0] r_gap_cnt;
    bus_cmd_t   w_req;
    bus_cmd_t   w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic       w_gap_done;

    assign w_req      = {req_addr, req_wdata};
    assign req_ready  = rstn & ~w_full;
    assign w_push     = req_valid & req_ready;
    assign w_gap_done = (r_state == ST_GAP) && (r_gap_cnt == 4'd0);
    // Back-to-back pops from WRITE only when no idle spacing is configured.
    assign w_pop      = ~w_empty & ((r_state == ST_IDLE) |
                                    ((r_state == ST_WRITE) && (GAP == 0)) |
                                    w_gap_done);
    assign busy       = ~w_empty | (r_state != ST_IDLE);

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_cmd_w)
    ) u_cmd_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_data  (w_req),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= 4'd0;
            en        <= 1'b0;
            wr        <= 1'b0;
            addr      <= 8'h00;
            wdata     <= 8'h00;
            wr_count  <= 16'h0000;
        end else begin
            if (r_state == ST_WRITE) wr_count <= wr_count + 16'd1;
            if (w_pop) begin
                r_state <= ST_WRITE;
                addr    <= w_head.addr;
                wdata   <= w_head.wdata;
                en      <= 1'b1;
                wr      <= 1'b1;
            end else begin
                en <= 1'b0;
                wr <= 1'b0;
                case (r_state)
                    ST_WRITE: begin
                        if (GAP > 0) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= c_gap_load;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_GAP: begin
                        if (r_gap_cnt == 4'd0) r_state <= ST_IDLE;
                        else                   r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
